// File: rtl/phase_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer_if
//  Description : Control/status bundle between the light FSM (master) and
//                the multi-phase countdown timer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface phase_timer_if #(
    parameter int CNT_W = 28,
    parameter int PH_W  = 2
);
    // Run control
    logic             enable;
    logic             start;
    logic [PH_W-1:0]  start_phase;
    logic             auto_adv;
    logic             abort;

    // Duration register write port
    logic             cfg_we;
    logic [PH_W-1:0]  cfg_idx;
    logic [CNT_W-1:0] cfg_dur;

    // Status
    logic             busy;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] count;
    logic             timeout;
    logic             cycle_done;

    modport master (
        output enable, start, start_phase, auto_adv, abort,
        output cfg_we, cfg_idx, cfg_dur,
        input  busy, phase, count, timeout, cycle_done
    );

    modport slave (
        input  enable, start, start_phase, auto_adv, abort,
        input  cfg_we, cfg_idx, cfg_dur,
        output busy, phase, count, timeout, cycle_done
    );
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Multi-phase countdown timer. One run-time writable duration
//                register per phase; counts the active phase down on an
//                enable tick, pulses timeout on each expiry and, in auto
//                mode, steps through all phases cyclically.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int               CNT_W       = 28,
    parameter int               PHASES      = 4,
    parameter int               PH_W        = $clog2(PHASES),
    parameter logic [CNT_W-1:0] DEFAULT_DUR = 28'd49_999_999
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    phase_timer_if.slave bus
);

    localparam logic [0:0]      S_IDLE = 1'b0;
    localparam logic [0:0]      S_RUN  = 1'b1;

    // Highest legal phase index; indices above it are rejected.
    localparam logic [PH_W-1:0] c_LAST_PHASE = PH_W'(PHASES - 1);
    // The duration table is padded to a power of two so any PH_W-wide index
    // selects a defined entry; padded entries are never reachable.
    localparam int              c_TBL_SIZE   = 2 ** PH_W;

    logic [0:0]       r_state;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_count;
    logic             r_timeout;
    logic             r_cycle_done;

    logic [0:0]       w_state_nxt;
    logic [PH_W-1:0]  w_phase_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_timeout_nxt;
    logic             w_cycle_done_nxt;

    logic [CNT_W-1:0] w_dur [0:c_TBL_SIZE-1];
    logic             w_start_ok;
    logic             w_cfg_ok;
    logic [PH_W-1:0]  w_succ_phase;

    assign w_start_ok   = bus.start && (bus.start_phase <= c_LAST_PHASE);
    assign w_cfg_ok     = bus.cfg_we && (bus.cfg_idx <= c_LAST_PHASE);
    // Explicit wrap keeps non-power-of-two phase counts correct.
    assign w_succ_phase = (r_phase == c_LAST_PHASE) ? '0 : r_phase + 1'b1;

    // Duration registers: one per real phase, constant zero for padding.
    // Loads read the registered value, so a same-cycle write is seen only
    // by the following load.
    generate
        for (genvar gi = 0; gi < c_TBL_SIZE; gi++) begin : g_dur
            if (gi < PHASES) begin : g_reg
                logic [CNT_W-1:0] r_dur;

                // Hold the duration of this phase; reload default on reset.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_dur <= DEFAULT_DUR;
                    end else if (w_cfg_ok && (bus.cfg_idx == PH_W'(gi))) begin
                        r_dur <= bus.cfg_dur;
                    end
                end

                assign w_dur[gi] = r_dur;
            end else begin : g_pad
                assign w_dur[gi] = '0;
            end
        end
    endgenerate

    // Register state, phase, count and the expiry pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_count      <= '0;
            r_timeout    <= 1'b0;
            r_cycle_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_count      <= w_count_nxt;
            r_timeout    <= w_timeout_nxt;
            r_cycle_done <= w_cycle_done_nxt;
        end
    end

    // Next-state decode: abort beats start, start beats expiry/decrement.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_count_nxt      = r_count;
        w_timeout_nxt    = 1'b0;
        w_cycle_done_nxt = 1'b0;

        if (bus.abort) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (w_start_ok) begin
            // Also a restart when already running; remaining count is dropped.
            w_state_nxt = S_RUN;
            w_phase_nxt = bus.start_phase;
            w_count_nxt = w_dur[bus.start_phase];
        end else if ((r_state == S_RUN) && bus.enable) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - 1'b1;
            end else begin
                w_timeout_nxt = 1'b1;
                if (bus.auto_adv) begin
                    // Reload immediately so phases run back to back.
                    w_phase_nxt      = w_succ_phase;
                    w_count_nxt      = w_dur[w_succ_phase];
                    w_cycle_done_nxt = (r_phase == c_LAST_PHASE);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    assign bus.busy       = (r_state == S_RUN);
    assign bus.phase      = r_phase;
    assign bus.count      = r_count;
    assign bus.timeout    = r_timeout;
    assign bus.cycle_done = r_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_timer
//  Description : Scoreboard bench for phase_timer (PHASES=4, CNT_W=8,
//                DEFAULT_DUR=3, PH_W=3 so out-of-range indices can be driven).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_timer;

    localparam int c_CNT_W  = 8;
    localparam int c_PHASES = 4;
    localparam int c_PH_W   = 3;
    localparam int c_DEF    = 3;

    logic clk;
    logic rst_n;

    phase_timer_if #(.CNT_W(c_CNT_W), .PH_W(c_PH_W)) bus ();

    phase_timer #(
        .CNT_W      (c_CNT_W),
        .PHASES     (c_PHASES),
        .PH_W       (c_PH_W),
        .DEFAULT_DUR(8'd3)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       busy;
        logic [2:0] phase;
        logic [7:0] count;
        logic       timeout;
        logic       cycle_done;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_run, m_phase, m_count;
    int m_dur [4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Predict the next outputs from the present inputs, then clock once and
    // compare against the DUT.
    task automatic tick();
        exp_t e;
        int   old [4];
        int   to, cd, sp;
        to = 0; cd = 0;
        old = m_dur;
        sp = int'(bus.start_phase);
        if (!rst_n) begin
            m_run = 0; m_phase = 0; m_count = 0;
            foreach (m_dur[i]) m_dur[i] = c_DEF;
        end else begin
            if (bus.abort) begin
                m_run = 0; m_count = 0;
            end else if (bus.start && sp < c_PHASES) begin
                m_run = 1; m_phase = sp; m_count = old[sp];
            end else if (m_run == 1 && bus.enable) begin
                if (m_count > 0) m_count = m_count - 1;
                else begin
                    to = 1;
                    if (bus.auto_adv) begin
                        cd = (m_phase == c_PHASES - 1) ? 1 : 0;
                        m_phase = (m_phase + 1) % c_PHASES;
                        m_count = old[m_phase];
                    end else begin
                        m_run = 0;
                    end
                end
            end
            if (bus.cfg_we && int'(bus.cfg_idx) < c_PHASES)
                m_dur[int'(bus.cfg_idx)] = int'(bus.cfg_dur);
        end
        e.busy = (m_run == 1); e.phase = 3'(m_phase); e.count = 8'(m_count);
        e.timeout = (to == 1); e.cycle_done = (cd == 1);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("busy",       32'(bus.busy),       32'(e.busy));
        check_val("phase",      32'(bus.phase),      32'(e.phase));
        check_val("count",      32'(bus.count),      32'(e.count));
        check_val("timeout",    32'(bus.timeout),    32'(e.timeout));
        check_val("cycle_done", 32'(bus.cycle_done), 32'(e.cycle_done));
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input int dur);
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_dur = 8'(dur);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start(input int sp, input logic aa);
        bus.start = 1'b1; bus.start_phase = 3'(sp); bus.auto_adv = aa;
        tick();
        bus.start = 1'b0;
    endtask

    int to_offs[$];
    int en_cnt;
    logic seen;

    initial begin
        m_run = 0; m_phase = 0; m_count = 0;
        foreach (m_dur[i]) m_dur[i] = 0;
        rst_n = 1'b0;
        bus.enable = 1'b1; bus.start = 1'b0; bus.start_phase = '0;
        bus.auto_adv = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_idx = '0; bus.cfg_dur = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single run from default duration: 3,2,1,0 then idle.
        do_start(0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check_val("single_idle_busy", 32'(bus.busy), 32'd0);

        // Enable pattern 1,0,0,1: expiry after exactly four enabled cycles.
        do_start(0, 1'b0);
        en_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.enable = (i % 4 == 0) || (i % 4 == 3);
            if (bus.enable) en_cnt++;
            tick();
            if (bus.timeout) seen = 1'b1;
        end
        bus.enable = 1'b1;
        check_val("en_toggle_seen", 32'(seen), 32'd1);
        check_val("en_toggle_cnt", 32'(en_cnt), 32'd4);

        // Abort together with start wins; out-of-range start is ignored.
        do_start(1, 1'b1);
        tick();
        bus.abort = 1'b1; bus.start = 1'b1; bus.start_phase = 3'd2;
        tick();
        idle_inputs();
        check_val("abort_count", 32'(bus.count), 32'd0);
        do_start(4, 1'b0);
        tick();
        check_val("bad_start_busy", 32'(bus.busy), 32'd0);
        cfg_write(5, 9);    // ignored index

        // Auto cycle with durations {2,0,5,1}.
        cfg_write(0, 2); cfg_write(1, 0); cfg_write(2, 5); cfg_write(3, 1);
        do_start(0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.timeout) to_offs.push_back(i);
        end
        check_val("auto_npulse", 32'(to_offs.size()), 32'd4);
        if (to_offs.size() == 4) begin
            check_val("auto_off0", 32'(to_offs[0]), 32'd3);
            check_val("auto_off1", 32'(to_offs[1]), 32'd4);
            check_val("auto_off2", 32'(to_offs[2]), 32'd10);
            check_val("auto_off3", 32'(to_offs[3]), 32'd12);
        end
        check_val("auto_wrap_cd", 32'(bus.cycle_done), 32'd1);
        check_val("auto_wrap_ph", 32'(bus.phase), 32'd0);

        // Rewrite phase 1 while it is running; applies on next pass only.
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        cfg_write(1, 4);
        do_start(1, 1'b1);
        for (int i = 0; i < 10 && bus.count != 8'd2; i++) tick();
        check_val("live_wr_at2", 32'(bus.count), 32'd2);
        cfg_write(1, 7);
        for (int i = 0; i < 30 && !(bus.phase == 3'd1 && !bus.timeout); i++) tick();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (bus.phase == 3'd1 && bus.timeout) seen = 1'b1;
        end
        check_val("live_wr_reload", 32'(bus.count), 32'd7);

        // Reset mid-run at count 1: everything cleared, defaults restored.
        for (int i = 0; i < 30 && bus.count != 8'd1; i++) tick();
        check_val("rst_at1", 32'(bus.count), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_start(1, 1'b1);
        check_val("rst_default_dur", 32'(bus.count), 32'd3);
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/phase_timer.md
# phase_timer

Parametrised multi-phase countdown timer for the traffic-light controller. It holds one duration register per phase, loaded with defaults at reset and rewritable at run time. It counts the active phase down on a clock-enable tick and flags each phase expiry. In auto mode it advances through all phases cyclically, replacing the fixed two-duration green/yellow timer with a single block that the light FSM starts and observes.

## Interface

Parameters:
- CNT_W, 28, counter and duration width (bits)
- PHASES, 4, number of phases (≥2)
- PH_W, $clog2(PHASES), phase index width
- DEFAULT_DUR, 28'd49_999_999, reset value of every duration register (1 s at 50 MHz with enable tied high)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  count tick; count holds while low
- start  in  1  load start_phase and begin running
- start_phase  in  PH_W  phase to load on start
- auto_adv  in  1  1 = on expiry load next phase (wrap PHASES-1→0); 0 = stop after expiry
- abort  in  1  stop immediately, return to IDLE
- cfg_we  in  1  write duration register
- cfg_idx  in  PH_W  duration register index
- cfg_dur  in  CNT_W  duration value (phase lasts cfg_dur+1 enabled cycles)
- busy  out  1  high in RUN
- phase  out  PH_W  current or last-run phase
- count  out  CNT_W  current remaining count
- timeout  out  1  one-cycle pulse per phase expiry
- cycle_done  out  1  one-cycle pulse when phase PHASES-1 expires with auto_adv=1

## Operation

- Reset (rst_n=0 at an edge): state IDLE; busy=0, phase=0, count=0, timeout=0, cycle_done=0; all dur[i]=DEFAULT_DUR.
- States: IDLE, RUN.
- IDLE → RUN on start with start_phase<PHASES: phase←start_phase, count←dur[start_phase].
- RUN, enable=1, count≠0: count←count-1.
- RUN, enable=1, count==0 (expiry):
  - timeout←1.
  - auto_adv=1: phase←(phase+1) mod PHASES, count←dur[next]; stay RUN. If phase was PHASES-1, also cycle_done←1.
  - auto_adv=0: go IDLE; count stays 0; phase holds.
- RUN, enable=0: count and phase hold; no expiry is evaluated.
- start in RUN: restart with start_phase, discarding the remaining count; no timeout is issued.
- abort (either state): IDLE, count←0, phase holds, no timeout.
- Priority in one cycle: rst_n > abort > start > expiry/decrement.
- start_phase ≥ PHASES: start is ignored (state unchanged).
- cfg_we with cfg_idx<PHASES: dur[cfg_idx]←cfg_dur in any state. cfg_idx ≥ PHASES: write ignored.
- A write to the active phase's register does not alter the running count; it applies at the next load.
- A write and a load of the same index in the same cycle: the load uses the old value.
- dur=0: phase expires on its first enabled cycle.
- No arithmetic overflow: count only decrements from a loaded value and stops at 0. Phase increment wraps explicitly (also correct for non-power-of-2 PHASES).

## Timing

- All outputs are registered; there are no combinational input→output paths.
- start sampled at edge k: at k+1, busy=1, count=dur[p], phase=p.
- A phase loaded with value D expires on the (D+1)th enabled cycle. timeout is high in the cycle after that edge, coincident with the reloaded count (auto) or with busy=0 (single).
- Auto mode with enable tied high: phase period is exactly D+1 cycles, with no gap cycle between phases.
- timeout and cycle_done are high for exactly one cycle and are never asserted by start or abort.
- Reset asserted mid-RUN: the outputs listed under reset take effect at the next edge, and any in-flight pulse is dropped.

## Test plan

All scenarios use PHASES=4, CNT_W=8, DEFAULT_DUR=3.

- Reset, then start with start_phase=0, auto_adv=0, enable=1 → busy for 4 cycles; count 3,2,1,0; timeout pulses once; busy=0 and phase=0 afterwards.
- Write dur={2,0,5,1}, then start with phase 0, auto_adv=1 → timeout pulses at cycle offsets 3,4,10,12; cycle_done coincides with the 4th pulse; phase sequence 0,1,2,3,0.
- In RUN, toggle enable 1,0,0,1 repeatedly → count holds on the 0 cycles; expiry occurs after exactly 4 enabled cycles.
- In RUN, assert abort and start together → IDLE, count=0, no timeout. Then start with start_phase=4 → ignored, busy stays 0.
- Write cfg_idx=1, cfg_dur=7 while phase 1 is running at count=2 → phase 1 still expires after 2 more enabled cycles; the next pass through phase 1 loads 7.
- Assert rst_n=0 for one cycle at count=1 in auto mode → next cycle all outputs are 0 and dur[] are back to 3; no timeout pulse is emitted.
